// File: rtl/judge_pkg.sv
// Shared definitions for the answer judge and the BCD score counter:
// verdict codes on the key bus and the judge FSM state encoding.
package judge_pkg;

    localparam logic [1:0] KEY_WRONG = 2'd0;
    localparam logic [1:0] KEY_RIGHT = 2'd1;
    localparam logic [1:0] KEY_NONE  = 2'd2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_WAIT    = S_WAIT,
        ST_REPORT  = S_REPORT,
        ST_RELEASE = S_RELEASE
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchronizer followed by a stability counter that
// accepts a new level after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned DEB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic [1:0]       sync;
    logic [DEB_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/answer_judge.sv
// Debounces the answer buttons and emits one single-cycle verdict per question.
// Optional answer window timeout: define ANSWER_TIMEOUT_EN.
module answer_judge #(
    parameter int unsigned NUM_BTN        = 4,
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned DEB_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned TMO_W          = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_on,
    input  logic               q_valid,
    input  logic [1:0]         answer,
    input  logic [NUM_BTN-1:0] btn,
    output logic [1:0]         key,
    output logic               q_done,
    output logic               busy
);

    import judge_pkg::*;

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] expect_oh;
    logic [1:0]         answer_q;
    logic               correct;
    logic               tmo_hit;

    state_t     state, state_n;
    logic [1:0] key_n;
    logic       q_done_n;
    logic       latch_answer;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .DEB_W     (DEB_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn[i]),
            .level(level[i])
        );
    end

    assign rise = level & ~level_d;

    // An out-of-range answer leaves expect_oh all-zero, so nothing can be correct.
    always_comb begin
        expect_oh = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            expect_oh[i] = (answer_q == 2'(i));
        end
    end

    assign correct = (|expect_oh) && (rise == expect_oh) && (level == expect_oh);

`ifdef ANSWER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        key_n        = KEY_NONE;
        q_done_n     = 1'b0;
        latch_answer = 1'b0;
        if (!game_on) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (q_valid) begin
                        state_n      = ST_WAIT;
                        latch_answer = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A rise in the timeout cycle still gets judged on its merits.
                    if (|rise) begin
                        state_n  = ST_REPORT;
                        key_n    = correct ? KEY_RIGHT : KEY_WRONG;
                        q_done_n = 1'b1;
                    end else if (tmo_hit) begin
                        state_n  = ST_REPORT;
                        key_n    = KEY_WRONG;
                        q_done_n = 1'b1;
                    end
                end
                ST_REPORT:  state_n = ST_RELEASE;
                ST_RELEASE: if (level == '0) state_n = ST_IDLE;
                default:    state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            key      <= KEY_NONE;
            q_done   <= 1'b0;
            answer_q <= 2'd0;
            level_d  <= '0;
        end else begin
            state   <= state_n;
            key     <= key_n;
            q_done  <= q_done_n;
            level_d <= level;
            if (latch_answer) answer_q <= answer;
        end
    end

    assign busy = (state == ST_WAIT);

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge with DEB_CYCLES=4 and TIMEOUT_CYCLES=50.
// The timeout case follows ANSWER_TIMEOUT_EN just like the design.
module tb_answer_judge;

    import judge_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_on;
    logic       q_valid;
    logic [1:0] answer;
    logic [3:0] btn;
    logic [1:0] key;
    logic       q_done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_right  = 0;
    int n_wrong  = 0;
    int qd_bad   = 0;
    int snap;
    int cyc;

    answer_judge #(
        .NUM_BTN       (4),
        .DEB_CYCLES    (4),
        .DEB_W         (3),
        .TIMEOUT_CYCLES(50),
        .TMO_W         (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .game_on(game_on),
        .q_valid(q_valid),
        .answer (answer),
        .btn    (btn),
        .key    (key),
        .q_done (q_done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Verdict monitor: counts every non-idle key cycle and checks q_done alignment.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key == KEY_RIGHT) n_right++;
            if (key == KEY_WRONG) n_wrong++;
            if (q_done != (key != KEY_NONE)) qd_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_q(input logic [1:0] ans);
        q_valid = 1'b1;
        answer  = ans;
        @(negedge clk);
        q_valid = 1'b0;
    endtask

    task automatic wait_key(input int max_cycles);
        int c = 0;
        while (key == KEY_NONE && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
    endtask

    function automatic int verdicts();
        return n_right + n_wrong;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        game_on = 1'b0;
        q_valid = 1'b0;
        answer  = 2'd0;
        btn     = 4'd0;
        tick(2);
        check("rst_key", 32'(key), 32'(KEY_NONE));
        check("rst_q_done", 32'(q_done), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n   = 1'b1;
        game_on = 1'b1;
        tick(2);

        // Correct press
        new_q(2'd2);
        check("correct_busy", 32'(busy), 1);
        snap = verdicts();
        btn[2] = 1'b1;
        wait_key(30);
        check("correct_key", 32'(key), 32'(KEY_RIGHT));
        check("correct_q_done", 32'(q_done), 1);
        check("correct_busy_fall", 32'(busy), 0);
        tick(1);
        check("correct_key_pulse", 32'(key), 32'(KEY_NONE));
        check("correct_q_done_pulse", 32'(q_done), 0);
        tick(18);
        btn = 4'd0;
        tick(12);
        check("correct_count", 32'(verdicts() - snap), 1);

        // Wrong button
        new_q(2'd1);
        snap = verdicts();
        btn[3] = 1'b1;
        wait_key(30);
        check("wrong_key", 32'(key), 32'(KEY_WRONG));
        tick(10);
        btn = 4'd0;
        tick(12);
        check("wrong_count", 32'(verdicts() - snap), 1);

        // Two buttons rising together, one of them correct
        new_q(2'd0);
        snap = verdicts();
        btn = 4'b0011;
        wait_key(30);
        check("double_key", 32'(key), 32'(KEY_WRONG));
        tick(10);
        btn = 4'd0;
        tick(12);
        check("double_count", 32'(verdicts() - snap), 1);

        // Bounce: toggling every 2 cycles never survives the debouncer
        new_q(2'd2);
        snap = verdicts();
        for (int i = 0; i < 15; i++) begin
            btn[2] = ~btn[2];
            tick(2);
        end
        check("bounce_quiet", 32'(verdicts() - snap), 0);
        check("bounce_busy", 32'(busy), 1);
        btn[2] = 1'b1;
        wait_key(30);
        check("bounce_key", 32'(key), 32'(KEY_RIGHT));
        tick(20);
        btn = 4'd0;
        tick(12);
        check("bounce_count", 32'(verdicts() - snap), 1);

        // Button already held when the question opens produces no rise
        btn[3] = 1'b1;
        tick(10);
        new_q(2'd3);
        snap = verdicts();
        tick(10);
        check("prehold_quiet", 32'(verdicts() - snap), 0);
        check("prehold_busy", 32'(busy), 1);
        btn[3] = 1'b0;
        tick(10);
        btn[3] = 1'b1;
        wait_key(30);
        check("prehold_key", 32'(key), 32'(KEY_RIGHT));
        tick(5);
        btn = 4'd0;
        tick(12);

        // Held across the verdict: next q_valid lands in RELEASE and is ignored
        new_q(2'd1);
        btn[1] = 1'b1;
        wait_key(30);
        check("held_first_key", 32'(key), 32'(KEY_RIGHT));
        tick(1);
        snap = verdicts();
        tick(3);
        new_q(2'd1);
        tick(20);
        check("held_no_second", 32'(verdicts() - snap), 0);
        check("held_busy", 32'(busy), 0);
        btn[1] = 1'b0;
        tick(12);
        new_q(2'd1);
        check("repress_busy", 32'(busy), 1);
        btn[1] = 1'b1;
        wait_key(30);
        check("repress_key", 32'(key), 32'(KEY_RIGHT));
        tick(5);
        btn = 4'd0;
        tick(12);

`ifdef ANSWER_TIMEOUT_EN
        // Timeout: wrong verdict 51 cycles after the q_valid cycle
        new_q(2'd3);
        cyc = 1;
        while (key == KEY_NONE && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_key", 32'(key), 32'(KEY_WRONG));
        check("timeout_cycle", 32'(cyc), 51);
        tick(5);
`else
        // No timeout: WAIT persists
        new_q(2'd3);
        snap = verdicts();
        tick(500);
        check("notimeout_key", 32'(key), 32'(KEY_NONE));
        check("notimeout_busy", 32'(busy), 1);
        check("notimeout_count", 32'(verdicts() - snap), 0);
        game_on = 1'b0;
        tick(2);
        game_on = 1'b1;
        tick(2);
`endif

        // Abort: game_on drops in WAIT
        new_q(2'd0);
        tick(3);
        snap = verdicts();
        game_on = 1'b0;
        tick(1);
        check("abort_busy", 32'(busy), 0);
        btn[0] = 1'b1;
        tick(12);
        check("abort_key", 32'(key), 32'(KEY_NONE));
        check("abort_count", 32'(verdicts() - snap), 0);
        btn = 4'd0;
        tick(12);
        new_q(2'd2);
        tick(1);
        check("idle_qvalid_ignored", 32'(busy), 0);
        game_on = 1'b1;
        tick(2);

        // Asynchronous reset in REPORT
        new_q(2'd2);
        btn[2] = 1'b1;
        wait_key(30);
        check("rst_report_key", 32'(key), 32'(KEY_RIGHT));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_key", 32'(key), 32'(KEY_NONE));
        check("async_rst_q_done", 32'(q_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        btn   = 4'd0;
        tick(12);
        check("post_rst_busy", 32'(busy), 0);

        check("q_done_alignment", 32'(qd_bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
